// File: rtl/shift_pkg.sv
// Shared types and constants for the shifter / collector datapath.
//   collect_state_t : collector FSM state (idle / mid-word)
//   ORDER_LSB/MSB   : assembly-order encoding, shared with shifter control
package shift_pkg;

    typedef enum logic {
        S_IDLE    = 1'b0,
        S_COLLECT = 1'b1
    } collect_state_t;

    localparam logic ORDER_LSB = 1'b0;
    localparam logic ORDER_MSB = 1'b1;

endpackage

// File: rtl/shift_collector_outreg.sv
// One-word output register with valid/ready drain.
//   clock_i, reset_i : clock, synchronous active-high reset
//   load_i           : a finished word is presented this cycle
//   load_data_i      : the finished word
//   out_ready_i      : consumer takes the word when valid && ready
//   out_data_o       : held word (stable while valid && !ready)
//   out_valid_o      : out_data_o holds an unconsumed word
module shift_collector_outreg #(
    parameter int WIDTH = 4
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_data_i,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] out_data_o,
    output logic             out_valid_o
);

    logic [WIDTH-1:0] data_q;
    logic             valid_q;

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else if (load_i) begin
            // A new word wins over a drain in the same cycle: no bubble.
            data_q  <= load_data_i;
            valid_q <= 1'b1;
        end else if (valid_q && out_ready_i) begin
            valid_q <= 1'b0;
        end
    end

    assign out_data_o  = data_q;
    assign out_valid_o = valid_q;

endmodule

// File: rtl/shift_collector.sv
// Serial-to-parallel collector: assembles the bit shifted out of the barrel
// shifter each step into WIDTH-bit words, LSB-first or MSB-first, and
// presents them on a valid/ready port through a one-word output register.
//   clock, reset         : clock, synchronous active-high reset
//   bit_in, bit_valid    : serial bit and its qualifier
//   bit_ready            : collector accepts bit_in this cycle
//   msb_first            : order for the next word (latched on its first bit)
//   flush                : discard the partial word in progress
//   out_data, out_valid  : finished word and its qualifier
//   out_ready            : consumer handshake
//   bit_count            : bits held in the current partial word
module shift_collector
    import shift_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNTW  = $clog2(WIDTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             bit_in,
    input  logic             bit_valid,
    output logic             bit_ready,
    input  logic             msb_first,
    input  logic             flush,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNTW-1:0]  bit_count
);

    collect_state_t   state_q;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CNTW-1:0]  cnt_q;
    logic             order_q;

    logic accept;
    logic last_bit;
    logic cur_order;
    logic word_done;

    assign last_bit = (cnt_q == CNTW'(WIDTH - 1));

    // Only the word-completing bit stalls, and only while the output
    // register is full and not draining this cycle.
    assign bit_ready = !reset && !flush && !(last_bit && out_valid && !out_ready);
    assign accept    = bit_valid && bit_ready;
    assign word_done = accept && last_bit;

    // The first bit of a word samples msb_first directly; later bits use the
    // latched order so mid-word changes are ignored.
    assign cur_order = (state_q == S_IDLE) ? msb_first : order_q;

    always_comb begin
        acc_d = acc_q;
        if (cur_order == ORDER_MSB) begin
            acc_d = {acc_q[WIDTH-2:0], bit_in};
        end else begin
            acc_d = {bit_in, acc_q[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            acc_q   <= '0;
            cnt_q   <= '0;
            order_q <= ORDER_LSB;
            state_q <= S_IDLE;
        end else if (flush) begin
            acc_q   <= '0;
            cnt_q   <= '0;
            state_q <= S_IDLE;
        end else if (accept) begin
            order_q <= cur_order;
            if (last_bit) begin
                acc_q   <= '0;
                cnt_q   <= '0;
                state_q <= S_IDLE;
            end else begin
                acc_q   <= acc_d;
                cnt_q   <= cnt_q + CNTW'(1);
                state_q <= S_COLLECT;
            end
        end
    end

    assign bit_count = cnt_q;

    shift_collector_outreg #(
        .WIDTH(WIDTH)
    ) u_outreg (
        .clock_i    (clock),
        .reset_i    (reset),
        .load_i     (word_done),
        .load_data_i(acc_d),
        .out_ready_i(out_ready),
        .out_data_o (out_data),
        .out_valid_o(out_valid)
    );

endmodule

// File: tb/tb_shift_collector.sv
module tb_shift_collector;

    localparam int W  = 4;
    localparam int CW = $clog2(W);

    logic          clock = 1'b0;
    logic          reset, bit_in, bit_valid, msb_first, flush, out_ready;
    logic          bit_ready, out_valid;
    logic [W-1:0]  out_data;
    logic [CW-1:0] bit_count;

    always #5 clock = ~clock;

    shift_collector #(.WIDTH(W)) dut (
        .clock    (clock),
        .reset    (reset),
        .bit_in   (bit_in),
        .bit_valid(bit_valid),
        .bit_ready(bit_ready),
        .msb_first(msb_first),
        .flush    (flush),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .bit_count(bit_count)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference: the partial word is a list of bits in arrival order; a word
    // is placed by position once all W bits are present.
    bit           mq[$];
    bit           m_order;
    logic [W-1:0] m_data;
    bit           m_valid;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit model_ready(bit rst, bit f, bit r);
        return !rst && !f && !(mq.size() == W - 1 && m_valid && !r);
    endfunction

    function automatic logic [W-1:0] build_word();
        logic [W-1:0] w = '0;
        for (int i = 0; i < W; i++) begin
            if (m_order) w[W-1-i] = mq[i];
            else         w[i]     = mq[i];
        end
        return w;
    endfunction

    // One cycle: drive at negedge, compare after settle, advance model at posedge.
    task automatic step(input bit rst, input bit v, input bit b, input bit m,
                        input bit f, input bit r, output bit rdy);
        bit exp_rdy, acc;
        @(negedge clock);
        reset = rst; bit_valid = v; bit_in = b; msb_first = m; flush = f; out_ready = r;
        #1;
        exp_rdy = model_ready(rst, f, r);
        rdy = bit_ready;
        check("bit_ready", 32'(bit_ready), 32'(exp_rdy));
        check("out_valid", 32'(out_valid), 32'(m_valid));
        check("out_data",  32'(out_data),  32'(m_data));
        check("bit_count", 32'(bit_count), 32'(mq.size()));
        acc = exp_rdy && v;
        @(posedge clock);
        if (rst) begin
            mq.delete(); m_valid = 0; m_data = '0; m_order = 0;
        end else begin
            if (m_valid && r) m_valid = 0;
            if (f) mq.delete();
            else if (acc) begin
                if (mq.size() == 0) m_order = m;
                mq.push_back(b);
                if (mq.size() == W) begin
                    m_data  = build_word();
                    m_valid = 1;
                    mq.delete();
                end
            end
        end
    endtask

    // Feeds s[W-1] first, down to s[0].
    task automatic feed(input logic [W-1:0] s, input bit m, input bit r);
        bit rdy;
        for (int i = W - 1; i >= 0; i--) step(0, 1, s[i], m, 0, r, rdy);
    endtask

    task automatic drain();
        bit rdy;
        step(0, 0, 0, 0, 0, 1, rdy);
    endtask

    initial begin
        bit rdy;
        @(negedge clock);
        reset = 1; bit_valid = 0; bit_in = 0; msb_first = 0; flush = 0; out_ready = 0;
        @(posedge clock);
        mq.delete(); m_valid = 0; m_data = '0; m_order = 0;

        // Shifter output for 1110 shifted right: 0,1,1,1 LSB-first.
        feed(4'b0111, 0, 0);
        #1;
        check("lit_1110_data",  32'(out_data),  32'h0000000E);
        check("lit_1110_valid", 32'(out_valid), 32'h1);
        drain();
        feed(4'b1001, 1, 0);
        #1; check("lit_1001_msb", 32'(out_data), 32'h9);
        drain();
        feed(4'b1001, 0, 0);
        #1; check("lit_1001_lsb", 32'(out_data), 32'h9);
        drain();
        feed(4'b1100, 0, 0);
        #1; check("lit_0011", 32'(out_data), 32'h3);
        drain();

        // Stall: out_ready low, stream 8 bits. Word A = 1,0,1,1 LSB -> 1101.
        feed(4'b1011, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step(0, 1, (i == 2), 0, 0, 0, rdy);
            check("stall_early_ready", 32'(rdy), 32'h1);
        end
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 0, 0, 0, 0, rdy);
            check("stall_last_ready", 32'(rdy), 32'h0);
        end
        #1; check("stall_word_a", 32'(out_data), 32'hD);
        step(0, 1, 0, 0, 0, 1, rdy);
        check("stall_release_ready", 32'(rdy), 32'h1);
        #1;
        check("stall_word_b", 32'(out_data), 32'h4);
        check("stall_b_valid", 32'(out_valid), 32'h1);
        drain();

        // Continuous stream with out_ready held high.
        feed(4'b0001, 1, 1);
        #1; check("b2b_w0", 32'(out_data), 32'h1);
        feed(4'b1110, 1, 1);
        #1; check("b2b_w1", 32'(out_data), 32'hE);
        feed(4'b0110, 0, 1);
        #1; check("b2b_w2", 32'(out_data), 32'h6);
        drain();

        // Flush mid-word with a bit offered in the same cycle.
        step(0, 1, 1, 0, 0, 0, rdy);
        step(0, 1, 1, 0, 0, 0, rdy);
        step(0, 1, 1, 0, 1, 0, rdy);
        check("flush_ready", 32'(rdy), 32'h0);
        #1; check("flush_count", 32'(bit_count), 32'h0);
        feed(4'b0100, 1, 0);
        #1; check("flush_clean_word", 32'(out_data), 32'h4);

        // Reset with a full output register and 3 bits pending.
        feed(4'b1010, 0, 0);
        #1; check("rst_pre_count", 32'(bit_count), 32'h3);
        step(0, 0, 0, 0, 0, 0, rdy);
        step(1, 1, 1, 0, 0, 1, rdy);
        check("rst_ready", 32'(rdy), 32'h0);
        #1;
        check("rst_data",  32'(out_data),  32'h0);
        check("rst_valid", 32'(out_valid), 32'h0);
        check("rst_count", 32'(bit_count), 32'h0);

        // Randomised traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 299) == 0),
                 ($urandom_range(0, 3) != 0),
                 1'($urandom()),
                 1'($urandom()),
                 ($urandom_range(0, 24) == 0),
                 ($urandom_range(0, 2) != 0),
                 rdy);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
